// File: rtl/uart_rx_ctrl_if.sv
// Bus bundle between the UART receive control block and its surroundings:
// serial-line tap, receiver data strobe, host config, parity outputs,
// FIFO read port and status.
interface uart_rx_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          RX_IN;
  logic          data_valid;
  logic [7:0]    P_DATA;
  logic          cfg_wr;
  logic          cfg_par_en;
  logic          cfg_par_typ;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          cfg_pending;
  logic          busy;
  logic          rd_valid;
  logic          rd_ready;
  logic [7:0]    rd_data;
  logic [LW-1:0] fifo_level;
  logic          ovf;
  logic          ovf_clr;
  logic [7:0]    frm_to_cnt;

  // Control block side
  modport slave (
    input  RX_IN, data_valid, P_DATA, cfg_wr, cfg_par_en, cfg_par_typ,
           rd_ready, ovf_clr,
    output PAR_EN, PAR_TYP, cfg_pending, busy, rd_valid, rd_data,
           fifo_level, ovf, frm_to_cnt
  );

  // Receiver / host / consumer side
  modport master (
    output RX_IN, data_valid, P_DATA, cfg_wr, cfg_par_en, cfg_par_typ,
           rd_ready, ovf_clr,
    input  PAR_EN, PAR_TYP, cfg_pending, busy, rd_valid, rd_data,
           fifo_level, ovf, frm_to_cnt
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive control: frame activity tracking with timeout, between-frame
// application of parity configuration, and a show-ahead byte FIFO with
// sticky overflow flag.
module uart_rx_ctrl #(
  parameter int DEPTH    = 4,
  parameter int FRAME_TO = 96,
  parameter int TO_W     = 7
) (
  input  logic          CLK,
  input  logic          RST,
  uart_rx_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t          state;
  state_t          state_n;
  logic            rx_q;
  logic [TO_W-1:0] timer;
  logic            timeout_hit;
  logic            start_edge;

  logic            sh_en;
  logic            sh_typ;
  logic            pending;
  logic            par_en;
  logic            par_typ;
  logic            apply;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic            full;
  logic            push_ok;
  logic            pop_ok;
  logic            ovf_q;
  logic [7:0]      to_cnt;

  assign start_edge = rx_q & ~bus.RX_IN;
  // A start edge is excluded so parity never changes on the cycle a frame begins.
  assign apply      = (state == IDLE) & pending & bus.RX_IN & ~start_edge;

  assign full    = (count == LW'(DEPTH));
  assign pop_ok  = bus.rd_ready & (count != '0);
  // When full, a push is only accepted if a pop frees the slot this cycle.
  assign push_ok = bus.data_valid & (~full | pop_ok);

  // Line sampler: one register stage on the serial input for edge detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rx_q <= 1'b1;
    else     rx_q <= bus.RX_IN;
  end

  // Frame FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Frame FSM next-state: a received byte ends the frame ahead of a coincident timeout
  always_comb begin
    state_n     = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) state_n = ACTIVE;
      end
      ACTIVE: begin
        if (bus.data_valid) begin
          state_n = IDLE;
        end else if (timer == TO_W'(FRAME_TO - 1)) begin
          state_n     = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Frame timer: held at zero while idle so each frame starts counting from 0
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                timer <= '0;
    else if (state == IDLE) timer <= '0;
    else                    timer <= timer + 1'b1;
  end

  // Saturating count of abandoned frames
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                             to_cnt <= '0;
    else if (timeout_hit && to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
  end

  // Config shadow: last host write wins; a write during an apply stays pending
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_en   <= 1'b0;
      sh_typ  <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (bus.cfg_wr) begin
        sh_en   <= bus.cfg_par_en;
        sh_typ  <= bus.cfg_par_typ;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

  // Applied parity config: moves only between frames with the line idle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_en  <= 1'b0;
      par_typ <= 1'b0;
    end else if (apply) begin
      par_en  <= sh_en;
      par_typ <= sh_typ;
    end
  end

  // FIFO storage and pointers; pointer width wraps naturally at DEPTH
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.P_DATA;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO occupancy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a new overflow beats a simultaneous clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                           ovf_q <= 1'b0;
    else if (bus.data_valid && !push_ok) ovf_q <= 1'b1;
    else if (bus.ovf_clr)              ovf_q <= 1'b0;
  end

  assign bus.PAR_EN      = par_en;
  assign bus.PAR_TYP     = par_typ;
  assign bus.cfg_pending = pending;
  assign bus.busy        = (state == ACTIVE);
  assign bus.rd_valid    = (count != '0);
  assign bus.rd_data     = mem[rd_ptr];
  assign bus.fifo_level  = count;
  assign bus.ovf         = ovf_q;
  assign bus.frm_to_cnt  = to_cnt;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed stimulus pushes expected FIFO
// bytes into a queue; a monitor compares every byte the consumer takes.
module tb_uart_rx_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [7:0] exp_q [$];

  uart_rx_ctrl_if #(.DEPTH(4)) bus ();

  uart_rx_ctrl #(.DEPTH(4), .FRAME_TO(96), .TO_W(7)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_kept);
    bus.data_valid = 1'b1;
    bus.P_DATA     = b;
    if (expect_kept) exp_q.push_back(b);
    tick();
    bus.data_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.rd_ready = 1'b1;
    while (bus.rd_valid && n < 20) begin
      tick();
      n++;
    end
    bus.rd_ready = 1'b0;
    chk("drain_empty", {31'd0, bus.rd_valid}, 32'd0);
  endtask

  // Monitor: every accepted read must match the oldest expected byte
  always @(negedge clk) begin
    if (!rst && bus.rd_valid && bus.rd_ready) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", {24'd0, bus.rd_data}, 32'hFFFF_FFFF);
      end else begin
        chk("rd_data", {24'd0, bus.rd_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.RX_IN = 1'b1;
    bus.data_valid = 1'b0;
    bus.P_DATA = 8'h00;
    bus.cfg_wr = 1'b0;
    bus.cfg_par_en = 1'b0;
    bus.cfg_par_typ = 1'b0;
    bus.rd_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    tick();
    tick();
    chk("rst_busy",    {31'd0, bus.busy}, 32'd0);
    chk("rst_rdvalid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_level",   {29'd0, bus.fifo_level}, 32'd0);
    chk("rst_ovf",     {31'd0, bus.ovf}, 32'd0);
    chk("rst_paren",   {31'd0, bus.PAR_EN}, 32'd0);
    chk("rst_tocnt",   {24'd0, bus.frm_to_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    tick();

    // 1: frame completes with a byte
    bus.RX_IN = 1'b0;
    tick();
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    repeat (9) tick();
    push_byte(8'hA5, 1'b1);
    chk("t1_busy_done", {31'd0, bus.busy}, 32'd0);
    chk("t1_rdvalid",   {31'd0, bus.rd_valid}, 32'd1);
    chk("t1_rddata",    {24'd0, bus.rd_data}, 32'hA5);
    chk("t1_level",     {29'd0, bus.fifo_level}, 32'd1);
    bus.RX_IN = 1'b1;
    drain();

    // 2: timeouts and saturation
    tick();
    for (int i = 0; i < 256; i++) begin
      bus.RX_IN = 1'b0;
      tick();
      repeat (95) tick();
      if (i == 0) chk("t2_busy_before", {31'd0, bus.busy}, 32'd1);
      tick();
      if (i == 0) begin
        chk("t2_busy_after", {31'd0, bus.busy}, 32'd0);
        chk("t2_cnt1", {24'd0, bus.frm_to_cnt}, 32'd1);
      end
      if (i == 254) chk("t2_cnt255", {24'd0, bus.frm_to_cnt}, 32'd255);
      bus.RX_IN = 1'b1;
      tick();
    end
    chk("t2_sat", {24'd0, bus.frm_to_cnt}, 32'd255);

    // 3: config write during a frame applies only after it
    bus.RX_IN = 1'b0;
    tick();
    bus.cfg_wr = 1'b1;
    bus.cfg_par_en = 1'b1;
    bus.cfg_par_typ = 1'b1;
    tick();
    bus.cfg_wr = 1'b0;
    chk("t3_pending", {31'd0, bus.cfg_pending}, 32'd1);
    chk("t3_paren_hold", {31'd0, bus.PAR_EN}, 32'd0);
    repeat (3) tick();
    chk("t3_paren_hold2", {31'd0, bus.PAR_EN}, 32'd0);
    bus.RX_IN = 1'b1;
    push_byte(8'h3C, 1'b1);
    chk("t3_idle", {31'd0, bus.busy}, 32'd0);
    chk("t3_paren_edge", {31'd0, bus.PAR_EN}, 32'd0);
    tick();
    chk("t3_paren",   {31'd0, bus.PAR_EN}, 32'd1);
    chk("t3_partyp",  {31'd0, bus.PAR_TYP}, 32'd1);
    chk("t3_pend_clr", {31'd0, bus.cfg_pending}, 32'd0);
    drain();

    // 4: overflow
    for (int b = 1; b <= 5; b++) push_byte(8'(b), b <= 4);
    chk("t4_level", {29'd0, bus.fifo_level}, 32'd4);
    chk("t4_ovf",   {31'd0, bus.ovf}, 32'd1);
    chk("t4_head",  {24'd0, bus.rd_data}, 32'h01);
    drain();
    chk("t4_ovf_sticky", {31'd0, bus.ovf}, 32'd1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("t4_ovf_clr", {31'd0, bus.ovf}, 32'd0);

    // 5: push and pop together while full
    for (int b = 0; b < 4; b++) push_byte(8'h11 + 8'(b), 1'b1);
    bus.rd_ready = 1'b1;
    push_byte(8'h77, 1'b1);
    bus.rd_ready = 1'b0;
    chk("t5_level", {29'd0, bus.fifo_level}, 32'd4);
    chk("t5_ovf",   {31'd0, bus.ovf}, 32'd0);
    drain();

    // 6: reset mid-frame with bytes queued
    push_byte(8'hC1, 1'b1);
    push_byte(8'hC2, 1'b1);
    push_byte(8'hC3, 1'b1);
    bus.RX_IN = 1'b0;
    tick();
    chk("t6_busy_pre",  {31'd0, bus.busy}, 32'd1);
    chk("t6_level_pre", {29'd0, bus.fifo_level}, 32'd3);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_busy",    {31'd0, bus.busy}, 32'd0);
    chk("t6_rdvalid", {31'd0, bus.rd_valid}, 32'd0);
    chk("t6_level",   {29'd0, bus.fifo_level}, 32'd0);
    chk("t6_rddata",  {24'd0, bus.rd_data}, 32'd0);
    chk("t6_paren",   {31'd0, bus.PAR_EN}, 32'd0);
    chk("t6_partyp",  {31'd0, bus.PAR_TYP}, 32'd0);
    chk("t6_tocnt",   {24'd0, bus.frm_to_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    bus.RX_IN = 1'b1;
    tick();
    chk("t6_rdvalid_post", {31'd0, bus.rd_valid}, 32'd0);
    chk("t6_busy_post",    {31'd0, bus.busy}, 32'd0);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Control and buffering block placed directly after the UART receiver top level.
- Tracks frame activity on the serial line and owns the receiver's parity configuration (PAR_EN/PAR_TYP). Host configuration writes are applied only between frames.
- Captures every received byte (P_DATA on a data_valid pulse) into a small show-ahead FIFO with a ready/valid read port.
- Counts frames that start but never complete, and flags overflow.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
FRAME_TO, 96, clocks after a start edge before an incomplete frame is abandoned; ≥ 88 (11 bits × 8 samples)
TO_W, 7, timeout counter width; 2^TO_W > FRAME_TO

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
RX_IN  in  1  serial line, same net as the receiver input
data_valid  in  1  one-cycle pulse from the receiver: P_DATA is valid
P_DATA  in  8  received byte
cfg_wr  in  1  host config write strobe
cfg_par_en  in  1  requested parity enable
cfg_par_typ  in  1  requested parity type (0 even, 1 odd)
PAR_EN  out  1  applied parity enable, to the receiver
PAR_TYP  out  1  applied parity type, to the receiver
cfg_pending  out  1  write accepted but not yet applied
busy  out  1  frame in progress (state ACTIVE)
rd_valid  out  1  FIFO not empty
rd_ready  in  1  consumer accepts head byte
rd_data  out  8  FIFO head byte
fifo_level  out  $clog2(DEPTH)+1  entries held
ovf  out  1  sticky overflow flag
ovf_clr  in  1  clears ovf
frm_to_cnt  out  8  saturating count of timed-out frames

Behaviour:
- Reset (asynchronous, active-high): all outputs 0. FIFO pointers and memory 0. rx_q = 1. State IDLE. Timer 0. Shadow config 0.
- rx_q: RX_IN registered once. Start edge = rx_q==1 && RX_IN==0.
- FSM, 2 states:
  - IDLE: start edge → ACTIVE, timer cleared to 0.
  - ACTIVE: timer increments each clock.
    - data_valid → IDLE (byte pushed, see FIFO).
    - Otherwise timer == FRAME_TO-1 → IDLE, frm_to_cnt += 1, saturating at 255.
    - data_valid wins if it coincides with the timeout cycle (no count).
  - data_valid arriving while in IDLE: byte still pushed; state unchanged.
  - busy = (state == ACTIVE), registered.
- Config:
  - cfg_wr loads the shadow registers and sets cfg_pending, in any state.
  - Apply condition: state IDLE && cfg_pending && RX_IN==1 && no start edge this cycle. When true: PAR_EN/PAR_TYP ← shadow on the next clock edge, and cfg_pending clears.
  - cfg_wr in the same cycle as an apply: the new value loads the shadow, cfg_pending stays 1, and the old shadow value is applied. The new value applies at the next eligible cycle.
  - Repeated cfg_wr while pending: last write wins.
  - PAR_EN/PAR_TYP never change while busy=1.
- FIFO (show-ahead):
  - push = data_valid. pop = rd_valid && rd_ready.
  - rd_data = mem[rd_ptr]; valid whenever rd_valid=1.
  - A byte pushed at edge N is visible (rd_valid=1, rd_data) after edge N.
  - Push when full without a simultaneous pop: byte dropped, ovf set, pointers unchanged.
  - Push and pop in the same cycle when full: both accepted, level stays DEPTH, no ovf.
  - Push and pop in the same cycle when empty: the push is accepted; the pop is impossible because rd_valid=0.
  - Pointers wrap modulo DEPTH. fifo_level = push count − pop count, range 0..DEPTH.
  - ovf_clr clears ovf. If ovf_clr and a new overflow occur together, ovf stays 1.
- Mid-operation reset: everything returns to reset values immediately. Bytes in the FIFO and any pending config are lost.

Test Plan:
1. Reset, then RX_IN falls; data_valid with P_DATA=0xA5 ten clocks later → busy=1 one clock after the edge. rd_valid=1, rd_data=0xA5, fifo_level=1 after the data_valid edge. busy=0.
2. RX_IN falls and stays low, no data_valid → after FRAME_TO=96 clocks busy=0 and frm_to_cnt=1. Repeat 256 times → frm_to_cnt saturates at 255.
3. cfg_wr with cfg_par_en=1, cfg_par_typ=1 while busy=1 → cfg_pending=1, PAR_EN=0 until the frame ends. One clock after IDLE with RX_IN=1: PAR_EN=1, PAR_TYP=1, cfg_pending=0.
4. rd_ready=0; push 0x01..0x05 → level=4, ovf=1, head=0x01. Pop all → bytes 0x01–0x04 in order. ovf_clr → ovf=0.
5. FIFO full; data_valid (0x77) and pop in the same cycle → level=4, ovf=0, and 0x77 is the last entry read out.
6. Assert RST mid-frame with 3 bytes queued → all outputs 0 immediately, and rd_valid=0 after RST is released.
